// File: rtl/countdown_s.sv
// countdown_s: two-digit BCD seconds countdown, consumer of the 1 s prescaler tick.
// Latency: start/cancel/tick take effect at the sampling edge; every output is registered or decoded from state flops.
// Backpressure: none. hold drops ticks and does not queue them. Ticks are level-sampled, one decrement per high cycle.
//
// Ports:
//   clk       system clock, rising edge
//   clr_n     asynchronous active-low reset
//   tick      1 s strobe, one clk wide
//   start     load load_val (or DEFAULT_SECS) and run; restarts if already running
//   cancel    abort to IDLE, highest priority
//   hold      level; while high, ticks are ignored
//   load_val  BCD seconds {tens, ones}
//   sec_bcd   remaining seconds, BCD
//   busy      high in RUN
//   expired   high in EXPIRED
//   done      one-cycle pulse on entry to EXPIRED
module countdown_s #(
  parameter logic [7:0] DEFAULT_SECS = 8'h30,
  parameter bit         AUTO_CLEAR   = 1'b1
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       tick,
  input  logic       start,
  input  logic       cancel,
  input  logic       hold,
  input  logic [7:0] load_val,
  output logic [7:0] sec_bcd,
  output logic       busy,
  output logic       expired,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] sec_nxt;
  logic       done_nxt;
  logic [7:0] load_sel;
  logic [7:0] sec_dec;
  logic       tick_ok;

  // Reject non-BCD nibbles and a zero load so the counter always starts at
  // a legal, non-zero BCD value and can never underflow.
  always_comb begin
    if ((load_val[7:4] > 4'd9) || (load_val[3:0] > 4'd9) || (load_val == 8'h00))
      load_sel = DEFAULT_SECS;
    else
      load_sel = load_val;
  end

  // BCD decrement with borrow from tens into ones.
  always_comb begin
    if (sec_bcd[3:0] == 4'd0)
      sec_dec = {sec_bcd[7:4] - 4'd1, 4'd9};
    else
      sec_dec = {sec_bcd[7:4], sec_bcd[3:0] - 4'd1};
  end

  assign tick_ok = tick && !hold;

  // State, count and done pulse registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= IDLE;
      sec_bcd <= 8'h00;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      sec_bcd <= sec_nxt;
      done    <= done_nxt;
    end
  end

  // Next-state: cancel beats start beats tick. A tick in the same cycle as
  // start is swallowed, so the freshly loaded value is never decremented.
  always_comb begin
    state_nxt = state;
    sec_nxt   = sec_bcd;
    done_nxt  = 1'b0;
    if (cancel) begin
      state_nxt = IDLE;
      sec_nxt   = 8'h00;
    end else if (start) begin
      state_nxt = RUN;
      sec_nxt   = load_sel;
    end else if (tick_ok) begin
      case (state)
        RUN: begin
          // <= 01 rather than == 01 keeps a stray 00 from wrapping to 99.
          if (sec_bcd <= 8'h01) begin
            state_nxt = EXPIRED;
            sec_nxt   = 8'h00;
            done_nxt  = 1'b1;
          end else begin
            sec_nxt = sec_dec;
          end
        end
        EXPIRED: begin
          if (AUTO_CLEAR)
            state_nxt = IDLE;
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  // Outputs decode only the state register, never the inputs.
  always_comb begin
    busy    = (state == RUN);
    expired = (state == EXPIRED);
  end

endmodule

// File: tb/tb_countdown_s.sv
// tb_countdown_s: scoreboard bench for countdown_s, one AUTO_CLEAR=1 and one AUTO_CLEAR=0 instance on shared inputs.
// Latency: stimulus pushes the expected outputs after the next rising edge; the monitor compares them on the falling edge.
// Backpressure: none; one scoreboard entry per driven cycle.
module tb_countdown_s;

  logic       clk;
  logic       clr_n;
  logic       tick, start, cancel, hold;
  logic [7:0] load_val;
  logic [7:0] sec1, sec0;
  logic       busy1, busy0, exp1, exp0, done1, done0;

  int n_chk;
  int n_fail;
  int cyc;
  int id;

  typedef struct {
    int          cyc;
    int          id;
    logic [10:0] e1;
    logic [10:0] e0;
  } exp_t;

  exp_t exp_q[$];

  countdown_s #(.DEFAULT_SECS(8'h30), .AUTO_CLEAR(1'b1)) dut1 (
    .clk(clk), .clr_n(clr_n), .tick(tick), .start(start), .cancel(cancel),
    .hold(hold), .load_val(load_val), .sec_bcd(sec1), .busy(busy1),
    .expired(exp1), .done(done1)
  );

  countdown_s #(.DEFAULT_SECS(8'h30), .AUTO_CLEAR(1'b0)) dut0 (
    .clk(clk), .clr_n(clr_n), .tick(tick), .start(start), .cancel(cancel),
    .hold(hold), .load_val(load_val), .sec_bcd(sec0), .busy(busy0),
    .expired(exp0), .done(done0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [10:0] ex(input logic [7:0] s, input logic b, input logic x, input logic d);
    return {s, b, x, d};
  endfunction

  task automatic chk(input string nm, input int tag, input logic [10:0] act, input logic [10:0] req);
    n_chk = n_chk + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s #%0d: got sec=%h busy=%b exp=%b done=%b, want sec=%h busy=%b exp=%b done=%b",
               nm, tag, act[10:3], act[2], act[1], act[0], req[10:3], req[2], req[1], req[0]);
    end
  endtask

  // Monitor: pop every entry whose target edge has passed.
  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("auto_clear1", e.id, {sec1, busy1, exp1, done1}, e.e1);
      chk("auto_clear0", e.id, {sec0, busy0, exp0, done0}, e.e0);
    end
  end

  task automatic step2(input logic t, input logic s, input logic c, input logic h,
                       input logic [7:0] lv, input logic [10:0] e1, input logic [10:0] e0);
    @(negedge clk);
    tick = t; start = s; cancel = c; hold = h; load_val = lv;
    exp_q.push_back('{cyc + 1, id, e1, e0});
    id = id + 1;
  endtask

  task automatic step(input logic t, input logic s, input logic c, input logic h,
                      input logic [7:0] lv, input logic [10:0] e);
    step2(t, s, c, h, lv, e, e);
  endtask

  localparam logic [10:0] Z = 11'h000;

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; id = 0;
    tick = 0; start = 0; cancel = 0; hold = 0; load_val = 8'h00;
    clr_n = 1'b1;
    #1 clr_n = 1'b0;

    // Reset state, stimulus ignored while in reset.
    step(0, 0, 0, 0, 8'h00, Z);
    step(1, 1, 0, 0, 8'h05, Z);
    step(0, 0, 0, 0, 8'h00, Z);
    @(negedge clk); clr_n = 1'b1;

    // IDLE ignores ticks.
    step(1, 0, 0, 0, 8'h00, Z);

    // Load 03, count to expiry.
    step(0, 1, 0, 0, 8'h03, ex(8'h03, 1, 0, 0));
    step(1, 0, 0, 0, 8'h00, ex(8'h02, 1, 0, 0));
    step(1, 0, 0, 0, 8'h00, ex(8'h01, 1, 0, 0));
    step(1, 0, 0, 0, 8'h00, ex(8'h00, 0, 1, 1));
    step(0, 0, 0, 0, 8'h00, ex(8'h00, 0, 1, 0));
    // Next tick clears only the AUTO_CLEAR instance; four more keep the other expired.
    step2(1, 0, 0, 0, 8'h00, Z, ex(8'h00, 0, 1, 0));
    for (int i = 0; i < 4; i++) step2(1, 0, 0, 0, 8'h00, Z, ex(8'h00, 0, 1, 0));
    step(0, 0, 1, 0, 8'h00, Z);

    // Borrow across digits and load substitution.
    step(0, 1, 0, 0, 8'h10, ex(8'h10, 1, 0, 0));
    step(1, 0, 0, 0, 8'h00, ex(8'h09, 1, 0, 0));
    step(0, 1, 0, 0, 8'h20, ex(8'h20, 1, 0, 0));
    step(1, 0, 0, 0, 8'h00, ex(8'h19, 1, 0, 0));
    step(0, 1, 0, 0, 8'h00, ex(8'h30, 1, 0, 0));
    step(0, 1, 0, 0, 8'h1A, ex(8'h30, 1, 0, 0));
    step(0, 1, 0, 0, 8'hF2, ex(8'h30, 1, 0, 0));
    step(0, 1, 0, 0, 8'hA1, ex(8'h30, 1, 0, 0));

    // Hold drops ticks.
    step(0, 1, 0, 0, 8'h05, ex(8'h05, 1, 0, 0));
    step(1, 0, 0, 1, 8'h00, ex(8'h05, 1, 0, 0));
    step(1, 0, 0, 1, 8'h00, ex(8'h05, 1, 0, 0));
    step(0, 0, 0, 0, 8'h00, ex(8'h05, 1, 0, 0));
    step(1, 0, 0, 0, 8'h00, ex(8'h04, 1, 0, 0));

    // Restart while running, start+tick, cancel+start.
    step(0, 1, 0, 0, 8'h20, ex(8'h20, 1, 0, 0));
    step(1, 1, 0, 0, 8'h07, ex(8'h07, 1, 0, 0));
    step(1, 0, 0, 0, 8'h00, ex(8'h06, 1, 0, 0));
    step(1, 1, 1, 0, 8'h09, Z);
    step(1, 0, 0, 0, 8'h00, Z);

    // Hold also blocks the clearing tick in EXPIRED.
    step(0, 1, 0, 0, 8'h01, ex(8'h01, 1, 0, 0));
    step(1, 0, 0, 0, 8'h00, ex(8'h00, 0, 1, 1));
    step(1, 0, 0, 1, 8'h00, ex(8'h00, 0, 1, 0));
    step2(1, 0, 0, 0, 8'h00, Z, ex(8'h00, 0, 1, 0));
    step(0, 1, 0, 0, 8'h00, ex(8'h30, 1, 0, 0));
    step(0, 0, 1, 0, 8'h00, Z);

    // Asynchronous reset mid-cycle at count 12.
    step(0, 1, 0, 0, 8'h12, ex(8'h12, 1, 0, 0));
    step(0, 0, 0, 0, 8'h00, ex(8'h12, 1, 0, 0));
    @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("async_reset1", -1, {sec1, busy1, exp1, done1}, Z);
    chk("async_reset0", -1, {sec0, busy0, exp0, done0}, Z);
    step(1, 0, 0, 0, 8'h00, Z);
    step(0, 0, 0, 0, 8'h00, Z);
    @(negedge clk); clr_n = 1'b1;
    step(1, 0, 0, 0, 8'h00, Z);
    step(1, 0, 0, 0, 8'h00, Z);
    step(0, 1, 0, 0, 8'h02, ex(8'h02, 1, 0, 0));
    step(1, 0, 0, 0, 8'h00, ex(8'h01, 1, 0, 0));
    step(1, 0, 0, 0, 8'h00, ex(8'h00, 0, 1, 1));
    step(0, 0, 0, 0, 8'h00, ex(8'h00, 0, 1, 0));

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    n_chk = n_chk + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
